// File: rtl/axi_burst_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_mem_responder
//  Description : AXI slave backed by on-chip block RAM. Serves the INCR,
//                64-bit-beat bursts issued by the Rocket memory adapter, one
//                transaction at a time (accept, data phase, response, idle).
//                Stands in for the PS HP0/DDR path in standalone FPGA builds
//                and in simulation.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset          sole clock (posedge) / synchronous active-high reset
//    aw*                 write address channel (awaddr byte address, awlen
//                        beats-1, awid)
//    w*                  write data channel (64-bit wdata, 8-bit wstrb, wlast)
//    b*                  write response (bid = latched awid, bresp OKAY/SLVERR)
//    ar*                 read address channel (araddr, arlen, arid)
//    r*                  read data channel (rdata, rid = latched arid,
//                        rresp always OKAY, rlast)
// ============================================================================
module axi_burst_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int ID_BITS   = 6
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               awvalid,
    output logic               awready,
    input  logic [31:0]        awaddr,
    input  logic [7:0]         awlen,
    input  logic [ID_BITS-1:0] awid,

    input  logic               wvalid,
    output logic               wready,
    input  logic [63:0]        wdata,
    input  logic [7:0]         wstrb,
    input  logic               wlast,

    output logic               bvalid,
    input  logic               bready,
    output logic [ID_BITS-1:0] bid,
    output logic [1:0]         bresp,

    input  logic               arvalid,
    output logic               arready,
    input  logic [31:0]        araddr,
    input  logic [7:0]         arlen,
    input  logic [ID_BITS-1:0] arid,

    output logic               rvalid,
    input  logic               rready,
    output logic [63:0]        rdata,
    output logic [ID_BITS-1:0] rid,
    output logic [1:0]         rresp,
    output logic               rlast
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_WRESP  = 3'd2,
        ST_RFETCH = 3'd3,
        ST_RDATA  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           beat_q, beat_d;
    logic [ID_BITS-1:0]   awid_q, awid_d;
    logic [ID_BITS-1:0]   arid_q, arid_d;
    logic                 err_q, err_d;
    logic [63:0]          rdata_q;

    logic [63:0]          mem [DEPTH];

    logic                 w_aw_hs;
    logic                 w_ar_hs;
    logic                 w_w_hs;
    logic                 w_r_hs;
    logic                 w_beat_is_last;
    logic [ADDR_BITS-1:0] w_beat_ext;
    logic [ADDR_BITS-1:0] w_wr_addr;
    logic [ADDR_BITS-1:0] w_rd_addr;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic                 w_unused_addr_bits;

    // ------------------------------------------------------------------------
    // Channel outputs. Address channels are closed during reset so nothing
    // can be accepted on the cycle reset is asserted.
    // ------------------------------------------------------------------------
    assign awready = (state_q == ST_IDLE) && !reset;
    // A same-cycle AW/AR tie goes to the write.
    assign arready = (state_q == ST_IDLE) && !awvalid && !reset;
    assign wready  = (state_q == ST_WDATA);
    assign bvalid  = (state_q == ST_WRESP);
    assign bid     = awid_q;
    assign bresp   = {bvalid && err_q, 1'b0};
    assign rvalid  = (state_q == ST_RDATA);
    assign rdata   = rdata_q;
    assign rid     = arid_q;
    assign rresp   = 2'b00;
    assign rlast   = rvalid && w_beat_is_last;

    assign w_aw_hs        = awvalid && awready;
    assign w_ar_hs        = arvalid && arready;
    assign w_w_hs         = wvalid && wready;
    assign w_r_hs         = rvalid && rready;
    assign w_beat_is_last = (beat_q == len_q);

    // Beat offsets wrap modulo the memory depth.
    assign w_beat_ext = ADDR_BITS'(beat_q);
    assign w_wr_addr  = idx_q + w_beat_ext;
    assign w_wr_en    = w_w_hs && !reset;

    // The RAM output is registered, so the read address looks one beat ahead
    // whenever the current beat is being consumed. That keeps one beat per
    // cycle under continuous rready and holds rdata steady while stalled.
    assign w_rd_addr = idx_q + w_beat_ext + ADDR_BITS'(w_r_hs);
    assign w_rd_en   = (state_q == ST_RFETCH) || (state_q == ST_RDATA);

    // Only the word index selects memory; byte offset and upper bits alias.
    assign w_unused_addr_bits = ^{awaddr[31:ADDR_BITS+3], awaddr[2:0],
                                  araddr[31:ADDR_BITS+3], araddr[2:0]};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        beat_d  = beat_q;
        awid_d  = awid_q;
        arid_d  = arid_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (w_aw_hs) begin
                    idx_d   = awaddr[ADDR_BITS+2:3];
                    len_d   = awlen;
                    awid_d  = awid;
                    beat_d  = 8'd0;
                    err_d   = 1'b0;
                    state_d = ST_WDATA;
                end else if (w_ar_hs) begin
                    idx_d   = araddr[ADDR_BITS+2:3];
                    len_d   = arlen;
                    arid_d  = arid;
                    beat_d  = 8'd0;
                    state_d = ST_RFETCH;
                end
            end

            ST_WDATA: begin
                if (w_w_hs) begin
                    beat_d = beat_q + 8'd1;
                    // wlast must coincide exactly with the beat count.
                    if (wlast != w_beat_is_last) begin
                        err_d = 1'b1;
                    end
                    // Leave on whichever of wlast / final beat comes first.
                    if (wlast || w_beat_is_last) begin
                        state_d = ST_WRESP;
                    end
                end
            end

            ST_WRESP: begin
                if (bready) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RFETCH: begin
                state_d = ST_RDATA;
            end

            ST_RDATA: begin
                if (w_r_hs) begin
                    if (w_beat_is_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            awid_q  <= '0;
            arid_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            awid_q  <= awid_d;
            arid_q  <= arid_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Block RAM: byte-enabled write port, registered read port. Contents are
    // deliberately not reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb[i]) begin
                    mem[w_wr_addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (w_rd_en) begin
            rdata_q <= mem[w_rd_addr];
        end
    end

endmodule
`default_nettype wire
